// File: rtl/alu_arbiter_if.sv
// Purpose: bundles the two requester ports, the ALU drive/return lines and the
//          tagged response bus of the ALU arbiter into one connection.
// Ports:   req/op/a/b per requester, ack per requester, alu_* towards the ALU,
//          alu_result/flags back, rsp_* response bus, busy, op_count.
//          slave modport = arbiter side, master modport = requesters + ALU side.
interface alu_arbiter_if #(
   parameter int unsigned DW  = 16,
   parameter int unsigned OPW = 6
);
   logic           req0;
   logic           req1;
   logic [OPW-1:0] op0;
   logic [OPW-1:0] op1;
   logic [DW-1:0]  a0;
   logic [DW-1:0]  a1;
   logic [DW-1:0]  b0;
   logic [DW-1:0]  b1;
   logic           ack0;
   logic           ack1;
   logic           alu_enable;
   logic [OPW-1:0] alu_opcode;
   logic [DW-1:0]  alu_term1;
   logic [DW-1:0]  alu_term2;
   logic [DW-1:0]  alu_result;
   logic           alu_zero;
   logic           alu_negative;
   logic           rsp_valid;
   logic           rsp_id;
   logic [DW-1:0]  rsp_result;
   logic           rsp_zero;
   logic           rsp_negative;
   logic           rsp_err;
   logic           busy;
   logic [15:0]    op_count;

   modport slave (
      input  req0, req1, op0, op1, a0, a1, b0, b1,
      input  alu_result, alu_zero, alu_negative,
      output ack0, ack1, alu_enable, alu_opcode, alu_term1, alu_term2,
      output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_negative, rsp_err,
      output busy, op_count
   );

   modport master (
      output req0, req1, op0, op1, a0, a1, b0, b1,
      output alu_result, alu_zero, alu_negative,
      input  ack0, ack1, alu_enable, alu_opcode, alu_term1, alu_term2,
      input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_negative, rsp_err,
      input  busy, op_count
   );
endinterface

// File: rtl/alu_arbiter.sv
// Purpose: shares one 16-bit ALU between two requesters, round-robin on ties,
//          blocks DIV/MOD by zero and returns id-tagged results.
// Latency: ack and alu_enable in the cycle after the accepting edge, rsp_valid
//          one cycle later; one operation per 3 cycles back to back.
// Backpressure: requests are ignored while busy; a req still high on return
//          to IDLE is treated as a new request.
// Ports:   clk, rst_b (async, active-low), bus (alu_arbiter_if.slave).
module alu_arbiter #(
   parameter int unsigned    DW          = 16,
   parameter int unsigned    OPW         = 6,
   parameter logic [DW-1:0]  DIVZERO_VAL = 16'hFFFF,
   parameter logic [OPW-1:0] OP_DIV      = 6'b000011,
   parameter logic [OPW-1:0] OP_MOD      = 6'b000100
) (
   input  logic         clk,
   input  logic         rst_b,
   alu_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_EXEC  = 2'd1,
      S_BLOCK = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;

   logic           r_prio;
   logic           r_owner;
   logic           r_ack0;
   logic           r_ack1;
   logic [OPW-1:0] r_alu_opcode;
   logic [DW-1:0]  r_alu_term1;
   logic [DW-1:0]  r_alu_term2;
   logic [DW-1:0]  r_rsp_result;
   logic           r_rsp_zero;
   logic           r_rsp_negative;
   logic           r_rsp_err;
   logic [15:0]    r_op_count;

   logic           w_grant;
   logic           w_win;
   logic [OPW-1:0] w_sel_op;
   logic [DW-1:0]  w_sel_a;
   logic [DW-1:0]  w_sel_b;
   logic           w_div_zero;

   // Winner selection, next state and state-decoded outputs.
   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_win       = 1'b0;
      w_sel_op    = bus.op0;
      w_sel_a     = bus.a0;
      w_sel_b     = bus.b0;
      w_div_zero  = 1'b0;

      // A lone request wins outright; a tie goes to the side named by r_prio.
      if (bus.req0 && bus.req1) begin
         w_win = r_prio;
      end else begin
         w_win = bus.req1;
      end

      if (w_win) begin
         w_sel_op = bus.op1;
         w_sel_a  = bus.a1;
         w_sel_b  = bus.b1;
      end

      w_div_zero = ((w_sel_op == OP_DIV) || (w_sel_op == OP_MOD)) &&
                   (w_sel_b == '0);

      case (r_state)
         S_IDLE: begin
            if (bus.req0 || bus.req1) begin
               w_grant     = 1'b1;
               w_state_nxt = w_div_zero ? S_BLOCK : S_EXEC;
            end
         end
         S_EXEC:  w_state_nxt = S_RESP;
         S_BLOCK: w_state_nxt = S_RESP;
         S_RESP:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase

      bus.alu_enable = (r_state == S_EXEC);
      bus.rsp_valid  = (r_state == S_RESP);
      bus.busy       = (r_state != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_prio         <= 1'b0;
         r_owner        <= 1'b0;
         r_ack0         <= 1'b0;
         r_ack1         <= 1'b0;
         r_alu_opcode   <= '0;
         r_alu_term1    <= '0;
         r_alu_term2    <= '0;
         r_rsp_result   <= '0;
         r_rsp_zero     <= 1'b0;
         r_rsp_negative <= 1'b0;
         r_rsp_err      <= 1'b0;
         r_op_count     <= '0;
      end else begin
         // Ack is a registered one-cycle pulse aligned with EXEC/BLOCK.
         r_ack0 <= w_grant && !w_win;
         r_ack1 <= w_grant && w_win;

         if (w_grant) begin
            r_owner      <= w_win;
            r_prio       <= ~w_win;
            r_alu_opcode <= w_sel_op;
            r_alu_term1  <= w_sel_a;
            r_alu_term2  <= w_sel_b;
         end

         if (r_state == S_EXEC) begin
            r_rsp_result   <= bus.alu_result;
            r_rsp_zero     <= bus.alu_zero;
            r_rsp_negative <= bus.alu_negative;
            r_rsp_err      <= 1'b0;
         end

         // Blocked op never reaches the ALU; synthesise a fixed answer.
         if (r_state == S_BLOCK) begin
            r_rsp_result   <= DIVZERO_VAL;
            r_rsp_zero     <= 1'b0;
            r_rsp_negative <= DIVZERO_VAL[DW-1];
            r_rsp_err      <= 1'b1;
         end

         if (r_state == S_RESP) begin
            r_op_count <= r_op_count + 16'd1;
         end
      end
   end

   assign bus.ack0         = r_ack0;
   assign bus.ack1         = r_ack1;
   assign bus.alu_opcode   = r_alu_opcode;
   assign bus.alu_term1    = r_alu_term1;
   assign bus.alu_term2    = r_alu_term2;
   assign bus.rsp_id       = r_owner;
   assign bus.rsp_result   = r_rsp_result;
   assign bus.rsp_zero     = r_rsp_zero;
   assign bus.rsp_negative = r_rsp_negative;
   assign bus.rsp_err      = r_rsp_err;
   assign bus.op_count     = r_op_count;

endmodule

// File: tb/tb_alu_arbiter.sv
// Purpose: self-checking bench for alu_arbiter with a behavioural ALU and an
//          operation-level reference model (arbitration, div-by-zero, count).
// Latency: expects ack/alu_enable one cycle after accept, rsp_valid one later.
// Backpressure: requesters hold req until acked, loser keeps waiting.
module tb_alu_arbiter;

   localparam logic [5:0] OP_ADD = 6'b000000;
   localparam logic [5:0] OP_SUB = 6'b000001;
   localparam logic [5:0] OP_DIV = 6'b000011;
   localparam logic [5:0] OP_MOD = 6'b000100;

   logic        clk   = 1'b0;
   logic        rst_b = 1'b1;
   int          n_chk = 0;
   int          n_err = 0;
   logic        m_prio  = 1'b0;
   logic [15:0] m_count = 16'd0;

   alu_arbiter_if bus ();

   alu_arbiter dut (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Behavioural ALU; its divide-by-zero answer is deliberately not 0xFFFF.
   function automatic logic [15:0] alu_fn(input logic [5:0] op,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
      case (op)
         6'd0:    return a + b;
         6'd1:    return a - b;
         6'd2:    return a & b;
         6'd3:    return (b == 16'd0) ? 16'h1234 : a / b;
         6'd4:    return (b == 16'd0) ? 16'h1234 : a % b;
         default: return a ^ b;
      endcase
   endfunction

   assign bus.alu_result   = alu_fn(bus.alu_opcode, bus.alu_term1, bus.alu_term2);
   assign bus.alu_zero     = (bus.alu_result == 16'd0);
   assign bus.alu_negative = bus.alu_result[15];

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ctl"}, {bus.ack0, bus.ack1, bus.alu_enable, bus.alu_opcode,
                          bus.alu_term1, bus.alu_term2}, '0);
      chk({tag, "_rsp"}, {bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_zero,
                          bus.rsp_negative, bus.rsp_err, bus.busy, bus.op_count}, '0);
   endtask

   // Services every pending request; called at a negedge with the DUT idle.
   task automatic serve();
      logic        win;
      logic        blk;
      logic [5:0]  op;
      logic [15:0] a, b, er;
      logic        ez, en, ee;
      for (int k = 0; k < 2 && (bus.req0 || bus.req1); k++) begin
         if (bus.req0 && bus.req1) win = m_prio;
         else                      win = bus.req1;
         m_prio = ~win;
         op  = win ? bus.op1 : bus.op0;
         a   = win ? bus.a1  : bus.a0;
         b   = win ? bus.b1  : bus.b0;
         blk = ((op == OP_DIV) || (op == OP_MOD)) && (b == 16'd0);
         if (blk) begin
            er = 16'hFFFF; ez = 1'b0; en = 1'b1; ee = 1'b1;
         end else begin
            er = alu_fn(op, a, b); ez = (er == 16'd0); en = er[15]; ee = 1'b0;
         end
         @(posedge clk); @(negedge clk);
         chk("ack0",    bus.ack0, !win);
         chk("ack1",    bus.ack1, win);
         chk("alu_en",  bus.alu_enable, !blk);
         chk("busy_x",  bus.busy, 1'b1);
         chk("alu_drv", {bus.alu_opcode, bus.alu_term1, bus.alu_term2}, {op, a, b});
         chk("rsp_v_x", bus.rsp_valid, 1'b0);
         if (win) bus.req1 = 1'b0;
         else     bus.req0 = 1'b0;
         @(posedge clk); @(negedge clk);
         chk("rsp_v",   bus.rsp_valid, 1'b1);
         chk("rsp_id",  bus.rsp_id, win);
         chk("rsp_res", bus.rsp_result, er);
         chk("rsp_flg", {bus.rsp_zero, bus.rsp_negative, bus.rsp_err}, {ez, en, ee});
         chk("ack_r",   {bus.ack0, bus.ack1, bus.alu_enable}, 3'b000);
         m_count = m_count + 16'd1;
         @(posedge clk); @(negedge clk);
         chk("rsp_v_d", bus.rsp_valid, 1'b0);
         chk("busy_i",  bus.busy, 1'b0);
         chk("op_cnt",  bus.op_count, m_count);
         chk("rsp_hld", {bus.rsp_id, bus.rsp_result, bus.rsp_err}, {win, er, ee});
      end
   endtask

   task automatic drive(input logic r0, input logic r1,
                        input logic [5:0] o0, input logic [15:0] x0, input logic [15:0] y0,
                        input logic [5:0] o1, input logic [15:0] x1, input logic [15:0] y1);
      bus.req0 = r0; bus.op0 = o0; bus.a0 = x0; bus.b0 = y0;
      bus.req1 = r1; bus.op1 = o1; bus.a1 = x1; bus.b1 = y1;
      serve();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
      $fatal(1);
   end

   initial begin
      bus.req0 = 1'b0; bus.op0 = '0; bus.a0 = '0; bus.b0 = '0;
      bus.req1 = 1'b0; bus.op1 = '0; bus.a1 = '0; bus.b1 = '0;
      #1 rst_b = 1'b0;
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      rst_b = 1'b1;
      @(negedge clk);

      // ADD, then SUB to zero and SUB going negative.
      drive(1'b1, 1'b0, OP_ADD, 16'h0003, 16'h0004, OP_ADD, 16'h0, 16'h0);
      chk("add_res", {bus.rsp_result, bus.rsp_zero, bus.rsp_negative}, {16'h0007, 2'b00});
      chk("add_cnt", bus.op_count, 16'd1);
      drive(1'b0, 1'b1, OP_ADD, 16'h0, 16'h0, OP_SUB, 16'h0005, 16'h0005);
      chk("sub_zero", {bus.rsp_id, bus.rsp_result, bus.rsp_zero}, {1'b1, 16'h0000, 1'b1});
      drive(1'b0, 1'b1, OP_ADD, 16'h0, 16'h0, OP_SUB, 16'h0001, 16'h0002);
      chk("sub_neg", {bus.rsp_result, bus.rsp_negative}, {16'hFFFF, 1'b1});

      // Tie while prio points back at requester 0.
      drive(1'b1, 1'b1, OP_ADD, 16'h0100, 16'h0001, OP_SUB, 16'h0100, 16'h0001);

      // Divide by zero is blocked, non-zero divisor is passed through.
      drive(1'b1, 1'b0, OP_DIV, 16'h0010, 16'h0000, OP_ADD, 16'h0, 16'h0);
      chk("div0", {bus.rsp_result, bus.rsp_err, bus.rsp_negative}, {16'hFFFF, 2'b11});
      drive(1'b1, 1'b0, OP_DIV, 16'h0010, 16'h0004, OP_ADD, 16'h0, 16'h0);
      chk("div4", {bus.rsp_result, bus.rsp_err}, {16'h0004, 1'b0});
      drive(1'b0, 1'b1, OP_ADD, 16'h0, 16'h0, OP_MOD, 16'h0007, 16'h0000);

      // Reset in the middle of EXEC.
      bus.req0 = 1'b1; bus.op0 = OP_ADD; bus.a0 = 16'h1111; bus.b0 = 16'h2222;
      @(posedge clk); @(negedge clk);
      chk("pre_rst_en", bus.alu_enable, 1'b1);
      bus.req0 = 1'b0;
      #1 rst_b = 1'b0;
      #1 chk_all_zero("rst_exec");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_quiet", {bus.rsp_valid, bus.ack0, bus.ack1}, 3'b000);
      end
      m_prio = 1'b0;
      m_count = 16'd0;
      // Both requests held across reset release: grant 0 then 1, then again.
      bus.req0 = 1'b1; bus.op0 = OP_ADD; bus.a0 = 16'h0001; bus.b0 = 16'h0001;
      bus.req1 = 1'b1; bus.op1 = OP_SUB; bus.a1 = 16'h0009; bus.b1 = 16'h0003;
      rst_b = 1'b1;
      chk("tie_prio", m_prio, 1'b0);
      serve();
      chk("post_rst_cnt", bus.op_count, 16'd2);
      drive(1'b1, 1'b1, OP_SUB, 16'h0000, 16'h0001, OP_ADD, 16'h7FFF, 16'h0001);

      // Randomised traffic.
      for (int it = 0; it < 60; it++) begin
         logic [1:0] m;
         m = 2'($urandom_range(1, 3));
         drive(m[0], m[1],
               6'($urandom_range(0, 5)), 16'($urandom),
               ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom),
               6'($urandom_range(0, 5)), 16'($urandom),
               ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // Counter wrap using a preloaded count.
      force dut.r_op_count = 16'hFFFF;
      @(posedge clk); @(negedge clk);
      release dut.r_op_count;
      chk("cnt_preload", bus.op_count, 16'hFFFF);
      m_count = 16'hFFFF;
      drive(1'b1, 1'b0, OP_ADD, 16'h0002, 16'h0002, OP_ADD, 16'h0, 16'h0);
      chk("cnt_wrap", bus.op_count, 16'h0000);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Sequences and shares the 16-bit ALU between two requesters (req 0: instruction execute unit, req 1: address/auxiliary unit). It accepts one operation at a time through a req/ack handshake and arbitrates ties round-robin. It drives the ALU's enable/opcode/operand inputs, captures the ALU result and flags into registers, and returns them on a shared response bus tagged with the requester id. It also blocks DIV/MOD by zero before the ALU sees it.

Parameters:
DW, 16, operand/result width
OPW, 6, opcode width
DIVZERO_VAL, 16'hFFFF, result returned for DIV/MOD with zero divisor
OP_DIV, 6'b000011, DIV opcode encoding
OP_MOD, 6'b000100, MOD opcode encoding

Ports:
clk  in  1  clock, rising edge
rst_b  in  1  reset, asynchronous, active-low
req0, req1  in  1 each  level request from requester 0 / 1
op0, op1  in  OPW each  opcode from requester 0 / 1
a0, a1  in  DW each  term1 from requester 0 / 1
b0, b1  in  DW each  term2 from requester 0 / 1
ack0, ack1  out  1 each  one-cycle accept pulse
alu_enable  out  1  ALU enable
alu_opcode  out  OPW  opcode to ALU
alu_term1, alu_term2  out  DW each  operands to ALU
alu_result  in  DW  ALU result
alu_zero, alu_negative  in  1 each  ALU flags
rsp_valid  out  1  one-cycle response strobe
rsp_id  out  1  requester the response belongs to
rsp_result  out  DW  captured result
rsp_zero, rsp_negative  out  1 each  captured flags
rsp_err  out  1  divide-by-zero was blocked
busy  out  1  high whenever state != IDLE
op_count  out  16  number of completed operations, wraps

Behaviour:
- Reset (async, rst_b low): state=IDLE, prio=0. All outputs are 0, including alu_opcode/terms, rsp_* and op_count. Reset mid-operation abandons the operation: no rsp_valid is issued and no ack is repeated.
- FSM: IDLE -> EXEC -> RESP -> IDLE. The only other path is IDLE -> BLOCK -> RESP -> IDLE, taken for divide-by-zero.
- IDLE, edge with any req high:
  - Select the winner. If only one req is high, that requester wins. If both are high, the requester indexed by prio wins.
  - Latch the winner's op/a/b into alu_opcode/alu_term1/alu_term2.
  - Set owner and pulse ack<winner> for the following cycle.
  - Set prio to the inverse of the winner.
  - Next state is EXEC. If the latched op is OP_DIV or OP_MOD with b==0, next state is BLOCK instead.
- EXEC: alu_enable=1 (decoded from the state register) for exactly one cycle. At the closing edge, register alu_result/alu_zero/alu_negative into rsp_result/rsp_zero/rsp_negative and set rsp_err=0. Next state is RESP.
- BLOCK: alu_enable stays 0. Load rsp_result=DIVZERO_VAL, rsp_zero=0, rsp_negative=DIVZERO_VAL[DW-1], rsp_err=1. Next state is RESP.
- RESP:
  - rsp_valid=1 for one cycle with rsp_id=owner.
  - op_count increments by 1 (mod 2^16), including for blocked ops.
  - Next state is IDLE.
- rsp_result/flags/err/id hold their values after rsp_valid drops until the next capture. alu_opcode/terms hold their last latched values while idle.
- Latency: request sampled at edge E0, ack high in cycle E0..E1, alu_enable high in E0..E1, rsp_valid high in E1..E2. Back-to-back throughput is one op per 3 cycles.
- Handshake:
  - A requester must drop req, or present a new op, in the cycle its ack is high.
  - The arbiter ignores req while not IDLE. A req still high when IDLE is re-entered counts as a new request.
  - Operands need only be valid during the accepting edge.
- Flags are taken from the ALU as-is. The arbiter does no arithmetic except the b==0 compare.
- ack0 and ack1 are never high together. rsp_valid and ack are never high in the same cycle.

Test Plan:
- After reset, req0 with ADD (000000), a0=0x0003, b0=0x0004 -> ack0 for 1 cycle, alu_enable for 1 cycle next to it, then rsp_valid with rsp_id=0, rsp_result=0x0007, zero=0, neg=0, err=0; op_count=1.
- req1 with SUB (000001), a1=0x0005, b1=0x0005 -> rsp_id=1, rsp_result=0x0000, rsp_zero=1. Then SUB 0x0001-0x0002 -> rsp_result=0xFFFF, rsp_negative=1.
- req0 and req1 both held continuously from reset, each releasing after its ack -> grant order is 0 then 1; a re-raised pair is granted 0, 1 again. Acks are 3 cycles apart, and ack0/ack1 are never simultaneous.
- req0 with DIV, a0=0x0010, b0=0x0000 -> alu_enable never asserts, rsp_result=0xFFFF, rsp_err=1, rsp_negative=1. The same with b0=0x0004 -> result 0x0004, err=0.
- Assert rst_b low during EXEC -> all outputs 0 immediately, no rsp_valid afterwards. The next request after reset is serviced normally, and a tie goes to req0.
- Force op_count to 0xFFFF by issuing 65535 ops (or use a preloaded-count bench shortcut), then issue one op -> op_count=0x0000.
